gain_channel_arbiter: RTL and testbench

Shares one pipelined gain (multiply + dequantize) datapath between the left and right audio channels of the FM radio chain. It pops samples from two show-ahead input FIFOs in round-robin order and scales each by that channel's programmable gain. Each result goes to the matching output FIFO. It replaces two gain_one_input instances after the L/R demix stage, halving multiplier use.

---
 rtl/gain_pkg.sv | 19 +
 rtl/gain_mul_stage.sv | 62 ++++++
 rtl/gain_channel_arbiter.sv | 96 +++++++++
 tb/tb_gain_channel_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gain_pkg.sv
// Shared types for the gain datapath: channel select and the S1 pipeline stage record.
package gain_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned QUANT_BITS = 10;

    typedef enum logic {
        CH_L = 1'b0,
        CH_R = 1'b1
    } ch_t;

    typedef struct packed {
        logic                         valid;
        ch_t                          ch;
        logic signed [DATA_WIDTH-1:0] data;
        logic signed [DATA_WIDTH-1:0] gain;
    } stage_t;

endpackage

// File: rtl/gain_mul_stage.sv
// Two-register multiply and truncating dequantize with valid/channel sideband.
// Stage 2 holds the full product, stage 3 the scaled result.
module gain_mul_stage
    import gain_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = gain_pkg::DATA_WIDTH,
    parameter int unsigned QUANT_BITS = gain_pkg::QUANT_BITS
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         in_valid,
    input  ch_t                          in_ch,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic signed [DATA_WIDTH-1:0] in_gain,
    output logic                         mid_valid,
    output ch_t                          mid_ch,
    output logic                         out_valid,
    output ch_t                          out_ch,
    output logic signed [DATA_WIDTH-1:0] out_data
);

    localparam int unsigned PW = 2 * DATA_WIDTH;
    localparam logic signed [PW-1:0] Bias = {{(PW - QUANT_BITS){1'b0}}, {QUANT_BITS{1'b1}}};

    logic signed [PW-1:0]         prod_d, prod_q, biased;
    logic signed [DATA_WIDTH-1:0] scaled;
    logic                         mid_valid_q, out_valid_q;
    ch_t                          mid_ch_q, out_ch_q;
    logic signed [DATA_WIDTH-1:0] out_data_q;

    always_comb begin
        prod_d = PW'(in_data) * PW'(in_gain);
        // Bias negatives so the arithmetic shift rounds toward zero, like C division.
        biased = prod_q + (prod_q[PW-1] ? Bias : '0);
        scaled = DATA_WIDTH'(biased >>> QUANT_BITS);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mid_valid_q <= 1'b0;
            mid_ch_q    <= CH_L;
            prod_q      <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= CH_L;
            out_data_q  <= '0;
        end else begin
            mid_valid_q <= in_valid;
            mid_ch_q    <= in_ch;
            prod_q      <= prod_d;
            out_valid_q <= mid_valid_q;
            out_ch_q    <= mid_ch_q;
            out_data_q  <= scaled;
        end
    end

    assign mid_valid = mid_valid_q;
    assign mid_ch    = mid_ch_q;
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_data  = out_data_q;

endmodule

// File: rtl/gain_channel_arbiter.sv
// Round-robin share of one gain pipeline between left and right channels.
// A channel is served only while none of its samples is in flight.
module gain_channel_arbiter
    import gain_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = gain_pkg::DATA_WIDTH,
    parameter int unsigned QUANT_BITS   = gain_pkg::QUANT_BITS,
    parameter int          DEFAULT_GAIN = 1024
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         cfg_wr_en,
    input  logic                         cfg_ch,
    input  logic signed [DATA_WIDTH-1:0] cfg_gain,
    output logic                         inL_rd_en,
    input  logic                         inL_empty,
    input  logic signed [DATA_WIDTH-1:0] inL_dout,
    output logic                         inR_rd_en,
    input  logic                         inR_empty,
    input  logic signed [DATA_WIDTH-1:0] inR_dout,
    output logic                         outL_wr_en,
    input  logic                         outL_full,
    output logic signed [DATA_WIDTH-1:0] outL_din,
    output logic                         outR_wr_en,
    input  logic                         outR_full,
    output logic signed [DATA_WIDTH-1:0] outR_din
);

    if (DATA_WIDTH != gain_pkg::DATA_WIDTH) begin : g_width_check
        $error("stage_t is sized by gain_pkg::DATA_WIDTH");
    end

    logic signed [DATA_WIDTH-1:0] gain_q [2];
    ch_t                          last_grant_q;
    stage_t                       s1_q;

    logic                         mid_valid, out_valid;
    ch_t                          mid_ch, out_ch;
    logic signed [DATA_WIDTH-1:0] out_data;

    logic busy_l, busy_r, elig_l, elig_r, grant_l, grant_r;

    always_comb begin
        busy_l = (s1_q.valid && s1_q.ch == CH_L) || (mid_valid && mid_ch == CH_L) ||
                 (out_valid && out_ch == CH_L);
        busy_r = (s1_q.valid && s1_q.ch == CH_R) || (mid_valid && mid_ch == CH_R) ||
                 (out_valid && out_ch == CH_R);
        elig_l  = !reset && !inL_empty && !outL_full && !busy_l;
        elig_r  = !reset && !inR_empty && !outR_full && !busy_r;
        grant_l = elig_l && (!elig_r || last_grant_q == CH_R);
        grant_r = elig_r && !grant_l;
    end

    assign inL_rd_en = grant_l;
    assign inR_rd_en = grant_r;

    always_ff @(posedge clock) begin
        if (reset) begin
            gain_q[0]    <= DATA_WIDTH'(DEFAULT_GAIN);
            gain_q[1]    <= DATA_WIDTH'(DEFAULT_GAIN);
            last_grant_q <= CH_R;
            s1_q         <= '0;
        end else begin
            // The grant below reads gain_q before this write lands.
            if (cfg_wr_en) gain_q[cfg_ch] <= cfg_gain;
            if (grant_l || grant_r) last_grant_q <= grant_r ? CH_R : CH_L;
            s1_q.valid <= grant_l || grant_r;
            s1_q.ch    <= grant_r ? CH_R : CH_L;
            s1_q.data  <= grant_r ? inR_dout : inL_dout;
            s1_q.gain  <= grant_r ? gain_q[1] : gain_q[0];
        end
    end

    gain_mul_stage #(
        .DATA_WIDTH(DATA_WIDTH),
        .QUANT_BITS(QUANT_BITS)
    ) u_mul (
        .clock    (clock),
        .reset    (reset),
        .in_valid (s1_q.valid),
        .in_ch    (s1_q.ch),
        .in_data  (s1_q.data),
        .in_gain  (s1_q.gain),
        .mid_valid(mid_valid),
        .mid_ch   (mid_ch),
        .out_valid(out_valid),
        .out_ch   (out_ch),
        .out_data (out_data)
    );

    assign outL_wr_en = out_valid && out_ch == CH_L;
    assign outR_wr_en = out_valid && out_ch == CH_R;
    assign outL_din   = outL_wr_en ? out_data : '0;
    assign outR_din   = outR_wr_en ? out_data : '0;

endmodule

// File: tb/tb_gain_channel_arbiter.sv
// Directed bench for gain_channel_arbiter: queue-backed FIFOs, a per-cycle reference model
// of the arbitration and scaling rules, and literal expectations per scenario.
module tb_gain_channel_arbiter;

    localparam int DW = 32;
    localparam int QB = 10;
    localparam int DEF_GAIN = 1024;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic cfg_wr_en = 1'b0;
    logic cfg_ch = 1'b0;
    logic signed [DW-1:0] cfg_gain = '0;
    logic inL_rd_en, inR_rd_en, outL_wr_en, outR_wr_en;
    logic inL_empty = 1'b1, inR_empty = 1'b1;
    logic outL_full = 1'b0, outR_full = 1'b0;
    logic signed [DW-1:0] inL_dout = '0, inR_dout = '0, outL_din, outR_din;

    gain_channel_arbiter #(
        .DATA_WIDTH  (DW),
        .QUANT_BITS  (QB),
        .DEFAULT_GAIN(DEF_GAIN)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .cfg_wr_en (cfg_wr_en),
        .cfg_ch    (cfg_ch),
        .cfg_gain  (cfg_gain),
        .inL_rd_en (inL_rd_en),
        .inL_empty (inL_empty),
        .inL_dout  (inL_dout),
        .inR_rd_en (inR_rd_en),
        .inR_empty (inR_empty),
        .inR_dout  (inR_dout),
        .outL_wr_en(outL_wr_en),
        .outL_full (outL_full),
        .outL_din  (outL_din),
        .outR_wr_en(outR_wr_en),
        .outR_full (outR_full),
        .outR_din  (outR_din)
    );

    always #5 clock = ~clock;

    int compared = 0;
    int mismatched = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Bench FIFOs and captured outputs
    int qL[$], qR[$], gotL[$], gotR[$], order[$];
    int first_rd = -1, first_wr = -1;
    logic pop_l = 0, pop_r = 0, push_l = 0, push_r = 0;
    int val_l = 0, val_r = 0;

    function automatic int at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -999999;
    endfunction

    task automatic refresh();
        inL_empty = (qL.size() == 0);
        inR_empty = (qR.size() == 0);
        inL_dout  = (qL.size() != 0) ? qL[0] : 0;
        inR_dout  = (qR.size() != 0) ? qR[0] : 0;
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
        if (pop_l && qL.size() != 0) void'(qL.pop_front());
        if (pop_r && qR.size() != 0) void'(qR.pop_front());
        if (push_l) gotL.push_back(val_l);
        if (push_r) gotR.push_back(val_r);
        pop_l = 0; pop_r = 0; push_l = 0; push_r = 0;
        refresh();
    endtask

    // Reference model: per-channel last grant cycle, scheduled outputs
    typedef struct {
        int due;
        int ch;
        int val;
    } ev_t;
    ev_t sched[$];
    int n = 0;
    int m_gain[2];
    int m_last = 1;
    int m_lastg[2];

    function automatic int scale(input int s, input int g);
        longint p;
        p = longint'(s) * longint'(g);
        return int'(p / (longint'(1) << QB));
    endfunction

    always @(negedge clock) begin
        bit el, er, gl, gr, wl, wr;
        int vl, vr;
        if (reset) begin
            chk("rst_rdL", inL_rd_en, 0);
            chk("rst_rdR", inR_rd_en, 0);
            m_gain[0] = DEF_GAIN; m_gain[1] = DEF_GAIN;
            m_last = 1;
            m_lastg[0] = -100; m_lastg[1] = -100;
            sched.delete();
            pop_l = 0; pop_r = 0; push_l = 0; push_r = 0;
        end else begin
            el = (qL.size() != 0) && !outL_full && (n - m_lastg[0] >= 4);
            er = (qR.size() != 0) && !outR_full && (n - m_lastg[1] >= 4);
            gl = el && (!er || m_last == 1);
            gr = er && !gl;
            chk("rdL", inL_rd_en, gl);
            chk("rdR", inR_rd_en, gr);
            if (gl || gr) begin
                ev_t e;
                e.due = n + 3;
                e.ch  = gr ? 1 : 0;
                e.val = gr ? scale(qR[0], m_gain[1]) : scale(qL[0], m_gain[0]);
                sched.push_back(e);
                m_last = e.ch;
                m_lastg[e.ch] = n;
                order.push_back(e.ch);
                if (first_rd < 0) first_rd = n;
            end
            wl = 0; wr = 0; vl = 0; vr = 0;
            for (int i = sched.size() - 1; i >= 0; i--) begin
                if (sched[i].due == n) begin
                    if (sched[i].ch == 0) begin wl = 1; vl = sched[i].val; end
                    else begin wr = 1; vr = sched[i].val; end
                    sched.delete(i);
                end
            end
            chk("wrL", outL_wr_en, wl);
            chk("wrR", outR_wr_en, wr);
            if (wl) chk("dinL", outL_din, vl);
            if (wr) chk("dinR", outR_din, vr);
            if ((outL_wr_en || outR_wr_en) && first_wr < 0) first_wr = n;
            if (cfg_wr_en) m_gain[cfg_ch] = cfg_gain;
            pop_l = inL_rd_en; pop_r = inR_rd_en;
            push_l = outL_wr_en; push_r = outR_wr_en;
            val_l = outL_din; val_r = outR_din;
        end
        n++;
    end

    task automatic do_reset();
        reset = 1'b1;
        cfg_wr_en = 1'b0;
        outL_full = 1'b0; outR_full = 1'b0;
        qL.delete(); qR.delete();
        refresh();
        cycle();
        reset = 1'b0;
        gotL.delete(); gotR.delete(); order.delete();
        first_rd = -1; first_wr = -1;
    endtask

    task automatic wait_out(input string name, input int nl, input int nr, input int budget);
        for (int i = 0; i < budget && (gotL.size() < nl || gotR.size() < nr); i++) cycle();
        chk(name, (gotL.size() >= nl && gotR.size() >= nr), 1);
        repeat (4) cycle();
    endtask

    task automatic cfg(input bit ch, input int g);
        cfg_wr_en = 1'b1; cfg_ch = ch; cfg_gain = g;
        cycle();
        cfg_wr_en = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        refresh();
        repeat (2) cycle();
        do_reset();
        chk("reset_dinL", outL_din, 0);
        chk("reset_dinR", outR_din, 0);
        chk("reset_wrL", outL_wr_en, 0);
        chk("reset_wrR", outR_wr_en, 0);

        // Unity gain, left only
        qL = '{1000, -1000, 7}; refresh();
        wait_out("t1_done", 3, 0, 40);
        chk("t1_L0", at(gotL, 0), 1000);
        chk("t1_L1", at(gotL, 1), -1000);
        chk("t1_L2", at(gotL, 2), 7);
        chk("t1_noR", gotR.size(), 0);
        chk("t1_latency", first_wr - first_rd, 3);

        // Per-channel gains, truncation toward zero
        do_reset();
        cfg(1'b0, 2048);
        cfg(1'b1, 512);
        qL = '{1000}; qR = '{-3}; refresh();
        wait_out("t2_done", 1, 1, 30);
        chk("t2_L", at(gotL, 0), 2000);
        chk("t2_R", at(gotR, 0), -1);
        chk("t2_first", at(order, 0), 0);
        chk("t2_second", at(order, 1), 1);

        // Back-to-back alternation
        do_reset();
        cfg(1'b0, 3000);
        cfg(1'b1, -700);
        qL = '{100, -200, 300, -400, 500, -600};
        qR = '{7, -8, 9, -10, 11, -12};
        refresh();
        wait_out("t3_done", 6, 6, 80);
        for (int i = 0; i < 12; i++) chk($sformatf("t3_order%0d", i), at(order, i), i % 2);
        chk("t3_L0", at(gotL, 0), 292);
        chk("t3_L1", at(gotL, 1), -585);
        chk("t3_R0", at(gotR, 0), -4);

        // Right output full blocks right only
        do_reset();
        outR_full = 1'b1;
        qL = '{1, 2, 3}; qR = '{4, 5, 6}; refresh();
        repeat (20) cycle();
        chk("t4_blockedR", gotR.size(), 0);
        chk("t4_servedL", gotL.size(), 3);
        outR_full = 1'b0;
        wait_out("t4_done", 3, 3, 40);
        chk("t4_R0", at(gotR, 0), 4);
        chk("t4_R2", at(gotR, 2), 6);

        // Gain write in the same cycle as the grant
        do_reset();
        qR = '{500, 700}; refresh();
        cfg_wr_en = 1'b1; cfg_ch = 1'b1; cfg_gain = 0;
        cycle();
        cfg_wr_en = 1'b0;
        wait_out("t5_done", 0, 2, 30);
        chk("t5_old_gain", at(gotR, 0), 500);
        chk("t5_new_gain", at(gotR, 1), 0);

        // Reset with two samples in flight
        do_reset();
        cfg(1'b0, 2048);
        qL = '{11, 22}; qR = '{33}; refresh();
        cycle();
        cycle();
        do_reset();
        repeat (8) cycle();
        chk("t6_droppedL", gotL.size(), 0);
        chk("t6_droppedR", gotR.size(), 0);
        qL = '{5}; refresh();
        wait_out("t6_done", 1, 0, 20);
        chk("t6_gain_reset", at(gotL, 0), 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
